// File: rtl/port_stats_regs_pkg.sv
// Shared register map, ID constants and helpers for the per-port statistics block.
package port_stats_regs_pkg;

   localparam int NUM_KINDS  = 4;
   localparam int PORT_SHIFT = 8;
   localparam logic [31:0] PORT_STRIDE = 32'h1 << PORT_SHIFT;

   localparam logic [7:0] OFF_RX_SUCC = 8'h00;
   localparam logic [7:0] OFF_RX_OF   = 8'h04;
   localparam logic [7:0] OFF_TX_SUCC = 8'h08;
   localparam logic [7:0] OFF_TX_FAIL = 8'h0C;
   localparam logic [7:0] OFF_SNAP    = 8'h10;
   localparam logic [7:0] OFF_CLR     = 8'h14;
   localparam logic [7:0] OFF_SNAP_RX_SUCC = 8'h20;
   localparam logic [7:0] OFF_SNAP_RX_OF   = 8'h24;
   localparam logic [7:0] OFF_SNAP_TX_SUCC = 8'h28;
   localparam logic [7:0] OFF_SNAP_TX_FAIL = 8'h2C;
   localparam logic [7:0] OFF_ID      = 8'hF0;

   localparam logic [7:0] ID_MAGIC   = 8'hA5;
   localparam logic [7:0] ID_VERSION = 8'h01;

   function automatic logic [31:0] swap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/gray_sync_bin.sv
// Brings one foreign-domain gray counter into clk: 2-flop synchroniser, gray->binary, output register.
module gray_sync_bin #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] gray_i,
   output logic [CNT_W-1:0] bin_o
);

   logic [CNT_W-1:0] sync1_q, sync2_q, bin_q;
   logic [CNT_W-1:0] sync1_d, sync2_d, bin_d;

   always_comb begin
      sync1_d = gray_i;
      sync2_d = sync1_q;
      bin_d   = '0;
      // each binary bit is the xor of all gray bits at or above it
      for (int i = 0; i < CNT_W; i++) begin
         bin_d[i] = ^(sync2_q >> i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         bin_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         bin_q   <= bin_d;
      end
   end

   assign bin_o = bin_q;

endmodule

// File: rtl/port_stats_regs.sv
// Memory-mapped per-port RX/TX statistics: synchronised gray counters with clearable baselines and snapshots.
module port_stats_regs
   import port_stats_regs_pkg::*;
#(
   parameter int          PORT_NUM  = 4,
   parameter int          CNT_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
   parameter bit          BYTE_SWAP = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [PORT_NUM*CNT_W-1:0] rx_succ_gray,
   input  logic [PORT_NUM*CNT_W-1:0] rx_of_gray,
   input  logic [PORT_NUM*CNT_W-1:0] tx_succ_gray,
   input  logic [PORT_NUM*CNT_W-1:0] tx_fail_gray,
   input  logic                      iomem_valid,
   output logic                      iomem_ready,
   input  logic [3:0]                iomem_wstrb,
   input  logic [31:0]               iomem_addr,
   input  logic [31:0]               iomem_wdata,
   output logic [31:0]               iomem_rdata
);

   logic [NUM_KINDS-1:0][PORT_NUM*CNT_W-1:0]   gray_all;
   logic [PORT_NUM-1:0][NUM_KINDS-1:0][CNT_W-1:0] bin, live;
   logic [PORT_NUM-1:0][NUM_KINDS-1:0][CNT_W-1:0] base_q, base_d, snap_q, snap_d;
   logic        ready_q, ready_d, done_q, done_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] rel;
   logic [23:0] pidx;
   logic [7:0]  off;
   logic        port_ok, mapped, accept, is_wr;
   logic [31:0] rd_val;
   logic        unused_wdata;

   assign unused_wdata = ^iomem_wdata;
   assign gray_all = {tx_fail_gray, tx_succ_gray, rx_of_gray, rx_succ_gray};

   for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_port
      for (genvar gk = 0; gk < NUM_KINDS; gk++) begin : g_kind
         gray_sync_bin #(.CNT_W(CNT_W)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .gray_i (gray_all[gk][gp*CNT_W +: CNT_W]),
            .bin_o  (bin[gp][gk])
         );
      end
   end

   // modular subtraction keeps deltas correct across counter wrap
   always_comb begin
      for (int p = 0; p < PORT_NUM; p++) begin
         for (int k = 0; k < NUM_KINDS; k++) begin
            live[p][k] = bin[p][k] - base_q[p][k];
         end
      end
   end

   always_comb begin
      rel     = iomem_addr - BASE_ADDR;
      pidx    = rel[31:PORT_SHIFT];
      off     = rel[PORT_SHIFT-1:0];
      port_ok = pidx < 24'(PORT_NUM);
      mapped  = 1'b0;
      if (port_ok) begin
         case (off)
            OFF_RX_SUCC, OFF_RX_OF, OFF_TX_SUCC, OFF_TX_FAIL,
            OFF_SNAP, OFF_CLR,
            OFF_SNAP_RX_SUCC, OFF_SNAP_RX_OF, OFF_SNAP_TX_SUCC, OFF_SNAP_TX_FAIL:
               mapped = 1'b1;
            OFF_ID:  mapped = (pidx == '0);
            default: mapped = 1'b0;
         endcase
      end
      is_wr  = |iomem_wstrb;
      // done_q blocks a re-accept while the master keeps valid high past the ack
      accept = iomem_valid && !ready_q && !done_q && mapped;
   end

   always_comb begin
      base_d = base_q;
      snap_d = snap_q;
      rd_val = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         if (pidx == 24'(p)) begin
            if (off[7:4] == 4'h0 && !off[4]) begin
               if (off[3:0] <= OFF_TX_FAIL[3:0]) begin
                  rd_val = 32'(live[p][off[3:2]]);
                  if (accept && is_wr) base_d[p][off[3:2]] = bin[p][off[3:2]];
               end
            end
            if (off[7:4] == 4'h2) rd_val = 32'(snap_q[p][off[3:2]]);
            if (accept && is_wr && off == OFF_SNAP) snap_d[p] = live[p];
            if (accept && is_wr && off == OFF_CLR)  base_d[p] = bin[p];
         end
      end
      if (off == OFF_ID && pidx == '0) begin
         rd_val = {ID_MAGIC, 8'(PORT_NUM), 8'(CNT_W), ID_VERSION};
      end
   end

   always_comb begin
      ready_d = accept;
      done_d  = accept ? 1'b1 : (iomem_valid ? done_q : 1'b0);
      rdata_d = '0;
      if (accept && !is_wr) begin
         rdata_d = BYTE_SWAP ? swap32(rd_val) : rd_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         base_q  <= '0;
         snap_q  <= '0;
      end else begin
         ready_q <= ready_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         base_q  <= base_d;
         snap_q  <= snap_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;

endmodule

// File: tb/tb_port_stats_regs.sv
// Directed bench for port_stats_regs: bus tasks push expectations, a negedge monitor pops and checks on each ack.
module tb_port_stats_regs;

   localparam int          PN   = 4;
   localparam int          CW   = 16;
   localparam logic [31:0] BASE = 32'h0300_0000;

   logic           clk = 1'b0;
   logic           rst;
   logic [PN*CW-1:0] rx_succ_gray, rx_of_gray, tx_succ_gray, tx_fail_gray;
   logic           iomem_valid;
   logic           iomem_ready;
   logic [3:0]     iomem_wstrb;
   logic [31:0]    iomem_addr, iomem_wdata, iomem_rdata;

   typedef struct {
      bit          chk;
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   acks  = 0;

   port_stats_regs #(.PORT_NUM(PN), .CNT_W(CW), .BASE_ADDR(BASE), .BYTE_SWAP(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_succ_gray (rx_succ_gray),
      .rx_of_gray   (rx_of_gray),
      .tx_succ_gray (tx_succ_gray),
      .tx_fail_gray (tx_fail_gray),
      .iomem_valid  (iomem_valid),
      .iomem_ready  (iomem_ready),
      .iomem_wstrb  (iomem_wstrb),
      .iomem_addr   (iomem_addr),
      .iomem_wdata  (iomem_wdata),
      .iomem_rdata  (iomem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] gray16(input int v);
      logic [15:0] b;
      b = v[15:0];
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] swp(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   task automatic set_cnt(input int kind, input int port, input int val);
      case (kind)
         0: rx_succ_gray[port*CW +: CW] = gray16(val);
         1: rx_of_gray[port*CW +: CW]   = gray16(val);
         2: tx_succ_gray[port*CW +: CW] = gray16(val);
         default: tx_fail_gray[port*CW +: CW] = gray16(val);
      endcase
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input bit chk,
                      input logic [31:0] expv, input string name);
      exp_t e;
      bit   got;
      e.chk = chk; e.data = expv; e.name = name;
      sb.push_back(e);
      got = 1'b0;
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (iomem_ready) begin
            got = 1'b1;
            break;
         end
      end
      iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      if (!got) begin
         total++; bad++;
         $display("FAIL %s: no ack within 20 cycles (ready=%b, want 1)", name, iomem_ready);
         void'(sb.pop_back());
      end
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] expv, input string name);
      bus(addr, 4'h0, 1'b1, expv, name);
   endtask

   task automatic wr(input logic [31:0] addr, input string name);
      bus(addr, 4'hF, 1'b0, 32'h0, name);
   endtask

   task automatic no_ack(input logic [31:0] addr, input string name);
      int seen;
      seen = 0;
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = 4'h0;
      repeat (16) begin
         @(negedge clk);
         if (iomem_ready) seen++;
      end
      iomem_valid = 1'b0;
      @(negedge clk);
      check(name, 32'(seen), 32'd0);
   endtask

   always @(negedge clk) begin
      if (iomem_ready) begin
         acks++;
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack: ready=1 addr=%h, want ready=0", iomem_addr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) begin
               total++;
               if (iomem_rdata !== e.data) begin
                  bad++;
                  $display("FAIL %s: rdata %h want %h", e.name, iomem_rdata, e.data);
               end
            end
         end
      end
   end

   initial begin
      int a0;
      rst = 1'b1;
      iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = '0; iomem_wdata = '0;
      rx_succ_gray = '0; rx_of_gray = '0; tx_succ_gray = '0; tx_fail_gray = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(iomem_ready), 32'd0);
      check("rst_rdata", iomem_rdata, 32'h0);
      rst = 1'b0;
      settle();

      // gray walk on port0 rx_succ
      for (int v = 0; v < 4; v++) begin
         set_cnt(0, 0, v);
         repeat (2) @(negedge clk);
      end
      settle();
      rd(BASE + 32'h000, 32'h0300_0000, "p0_rx_succ_3");

      // CLR then advance
      set_cnt(3, 2, 100);
      settle();
      wr(BASE + 32'h214, "p2_clr");
      set_cnt(3, 2, 105);
      settle();
      rd(BASE + 32'h20C, 32'h0500_0000, "p2_tx_fail_delta5");
      rd(BASE + 32'h200, 32'h0, "p2_rx_succ_zero");

      // wrap-around through a per-counter clear
      set_cnt(0, 3, 9);
      set_cnt(1, 3, 16'hFFFE);
      settle();
      wr(BASE + 32'h304, "p3_rx_of_clr");
      set_cnt(1, 3, 3);
      settle();
      rd(BASE + 32'h304, swp(32'd5), "p3_rx_of_wrap");
      rd(BASE + 32'h300, swp(32'd9), "p3_rx_succ_kept");

      // snapshot
      set_cnt(0, 1, 7); set_cnt(1, 1, 0); set_cnt(2, 1, 9); set_cnt(3, 1, 2);
      settle();
      wr(BASE + 32'h110, "p1_snap");
      set_cnt(0, 1, 10); set_cnt(1, 1, 1); set_cnt(2, 1, 20); set_cnt(3, 1, 3);
      settle();
      wr(BASE + 32'h120, "p1_snap_wr_ignored");
      rd(BASE + 32'h120, swp(32'd7),  "p1_snap_rx_succ");
      rd(BASE + 32'h124, swp(32'd0),  "p1_snap_rx_of");
      rd(BASE + 32'h128, swp(32'd9),  "p1_snap_tx_succ");
      rd(BASE + 32'h12C, swp(32'd2),  "p1_snap_tx_fail");
      rd(BASE + 32'h100, swp(32'd10), "p1_live_rx_succ");
      rd(BASE + 32'h104, swp(32'd1),  "p1_live_rx_of");
      rd(BASE + 32'h108, swp(32'd20), "p1_live_tx_succ");
      rd(BASE + 32'h10C, swp(32'd3),  "p1_live_tx_fail");

      // decode: unmapped holes, ID, write-only regs
      no_ack(BASE + 32'h018, "unmapped_018");
      no_ack(BASE + 32'h400, "unmapped_port4");
      no_ack(BASE + 32'h1F0, "unmapped_id_p1");
      no_ack(BASE + 32'h002, "unmapped_unaligned");
      rd(BASE + 32'h0F0, 32'h0110_04A5, "id");
      rd(BASE + 32'h110, 32'h0, "snap_reads_0");
      rd(BASE + 32'h014, 32'h0, "clr_reads_0");
      wr(BASE + 32'h0F0, "id_wr_ignored");
      rd(BASE + 32'h0F0, 32'h0110_04A5, "id_after_wr");

      // CLR with valid held across the ack
      set_cnt(2, 0, 4);
      settle();
      rd(BASE + 32'h008, swp(32'd4), "p0_tx_succ_4");
      begin
         exp_t e;
         e.chk = 1'b0; e.data = '0; e.name = "p0_clr_hold";
         sb.push_back(e);
      end
      a0 = acks;
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = BASE + 32'h014; iomem_wstrb = 4'hF;
      repeat (3) @(negedge clk);
      iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      @(negedge clk);
      check("hold_one_ack", 32'(acks - a0), 32'd1);
      rd(BASE + 32'h000, 32'h0, "p0_rx_succ_cleared");
      rd(BASE + 32'h008, 32'h0, "p0_tx_succ_cleared");
      set_cnt(0, 0, 5);
      settle();
      rd(BASE + 32'h000, swp(32'd2), "p0_rx_succ_after_clr");

      // reset in the cycle after valid aborts the transaction
      a0 = acks;
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = BASE + 32'h000; iomem_wstrb = 4'h0;
      @(posedge clk);
      #1 rst = 1'b1;
      rx_succ_gray = '0; rx_of_gray = '0; tx_succ_gray = '0; tx_fail_gray = '0;
      repeat (3) @(negedge clk);
      check("midrst_ready", 32'(iomem_ready), 32'd0);
      check("midrst_rdata", iomem_rdata, 32'h0);
      iomem_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("midrst_no_ack", 32'(acks - a0), 32'd0);
      settle();
      rd(BASE + 32'h000, 32'h0, "post_rst_p0_rx_succ");
      rd(BASE + 32'h108, 32'h0, "post_rst_p1_tx_succ");
      rd(BASE + 32'h120, 32'h0, "post_rst_p1_snap");
      set_cnt(0, 0, 6);
      settle();
      rd(BASE + 32'h000, swp(32'd6), "post_rst_no_baseline");

      repeat (4) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
